// File: rtl/pwm_sar_adc_ctrl_pkg.sv
// Shared definitions for the PWM-DAC successive-approximation ADC sequencer:
// state encodings, default parameters and a counter-width helper.
package pwm_sar_adc_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      SAMPLE = 2'd2,
      DONE   = 2'd3
   } adc_state_t;

   localparam int DEF_DATA_W         = 8;
   localparam int DEF_SETTLE_PERIODS = 16;

   // Width needed to count 0..limit-1, never narrower than one bit.
   function automatic int cnt_width(input int limit);
      return (limit > 1) ? $clog2(limit) : 1;
   endfunction

endpackage

// File: rtl/pwm_sar_adc_ctrl_if.sv
// CPU-side control/result bundle of the SAR ADC sequencer.
interface pwm_sar_adc_ctrl_if #(
   parameter int DATA_W = 8
) ();

   logic              start;
   logic              cont_en;
   logic              abort;
   logic              busy;
   logic [DATA_W-1:0] data_out;
   logic              valid;

   modport master (
      output start, cont_en, abort,
      input  busy, data_out, valid
   );

   modport slave (
      input  start, cont_en, abort,
      output busy, data_out, valid
   );

endinterface

// File: rtl/pwm_sar_adc_ctrl_pwm_dac_gen.sv
// PWM-DAC generator: free-running period counter, duty compare and a
// registered drive output, plus a strobe on the last count of each period.
module pwm_dac_gen #(
   parameter int DATA_W = 8
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              clr,
   input  logic              en,
   input  logic [DATA_W-1:0] duty,
   output logic              ad_pwm,
   output logic              wrap
);

   logic [DATA_W-1:0] pwm_cnt;

   // wrap marks the cycle whose edge rolls pwm_cnt back to zero
   assign wrap = en && (pwm_cnt == {DATA_W{1'b1}});

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         pwm_cnt <= '0;
         ad_pwm  <= 1'b0;
      end else begin
         if (clr) begin
            pwm_cnt <= '0;
         end else if (en) begin
            pwm_cnt <= pwm_cnt + DATA_W'(1);
         end
         ad_pwm <= en && (pwm_cnt < duty);
      end
   end

endmodule

// File: rtl/pwm_sar_adc_ctrl.sv
// Successive-approximation sequencer: drives a PWM reference, waits for the RC
// filter to settle, samples the synchronised comparator and binary-searches the code.
module pwm_sar_adc_ctrl
   import pwm_sar_adc_ctrl_pkg::*;
#(
   parameter int DATA_W         = DEF_DATA_W,
   parameter int SETTLE_PERIODS = DEF_SETTLE_PERIODS
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                comp_in,
   output logic                ad_pwm,
   pwm_sar_adc_ctrl_if.slave   bus
);

   localparam int PER_W = cnt_width(SETTLE_PERIODS);
   localparam int IDX_W = cnt_width(DATA_W);
   localparam logic [DATA_W-1:0] TRIAL_INIT = {1'b1, {(DATA_W-1){1'b0}}};
   localparam logic [PER_W-1:0]  PER_LAST   = PER_W'(SETTLE_PERIODS - 1);
   localparam logic [IDX_W-1:0]  IDX_INIT   = IDX_W'(DATA_W - 1);

   adc_state_t        state;
   logic [DATA_W-1:0] trial;
   logic [IDX_W-1:0]  bit_idx;
   logic [PER_W-1:0]  per_cnt;
   logic [1:0]        comp_sync;
   logic              busy_r;
   logic              valid_r;
   logic [DATA_W-1:0] data_r;

   logic              pwm_en;
   logic              pwm_clr;
   logic              pwm_wrap;
   logic [DATA_W-1:0] sample_result;

   assign bus.busy     = busy_r;
   assign bus.valid    = valid_r;
   assign bus.data_out = data_r;

   // Comparator is asynchronous to clock, so it is always resynchronised
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         comp_sync <= 2'b00;
      end else begin
         comp_sync <= {comp_sync[0], comp_in};
      end
   end

   // The PWM only runs while settling; outside SETTLE its counter sits at zero
   assign pwm_en  = (state == SETTLE) && !bus.abort;
   assign pwm_clr = !pwm_en;

   // trial already carries the decided upper bits, so clearing the bit under test
   // on a low comparator gives the partial result directly
   assign sample_result = comp_sync[1] ? trial : (trial & ~(DATA_W'(1) << bit_idx));

   pwm_dac_gen #(
      .DATA_W (DATA_W)
   ) u_pwm_dac_gen (
      .clock  (clock),
      .reset  (reset),
      .clr    (pwm_clr),
      .en     (pwm_en),
      .duty   (trial),
      .ad_pwm (ad_pwm),
      .wrap   (pwm_wrap)
   );

   // Sequencer FSM; valid and data_out are registered on the edge entering DONE
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state   <= IDLE;
         trial   <= TRIAL_INIT;
         bit_idx <= IDX_INIT;
         per_cnt <= '0;
         busy_r  <= 1'b0;
         valid_r <= 1'b0;
         data_r  <= '0;
      end else begin
         valid_r <= 1'b0;
         if (bus.abort) begin
            state  <= IDLE;
            busy_r <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  if (bus.start) begin
                     trial   <= TRIAL_INIT;
                     bit_idx <= IDX_INIT;
                     per_cnt <= '0;
                     busy_r  <= 1'b1;
                     state   <= SETTLE;
                  end
               end
               SETTLE: begin
                  if (pwm_wrap) begin
                     if (per_cnt == PER_LAST) begin
                        per_cnt <= '0;
                        state   <= SAMPLE;
                     end else begin
                        per_cnt <= per_cnt + PER_W'(1);
                     end
                  end
               end
               SAMPLE: begin
                  if (bit_idx == '0) begin
                     data_r  <= sample_result;
                     valid_r <= 1'b1;
                     state   <= DONE;
                  end else begin
                     bit_idx <= bit_idx - IDX_W'(1);
                     trial   <= sample_result | (DATA_W'(1) << (bit_idx - IDX_W'(1)));
                     per_cnt <= '0;
                     state   <= SETTLE;
                  end
               end
               DONE: begin
                  if (bus.cont_en) begin
                     trial   <= TRIAL_INIT;
                     bit_idx <= IDX_INIT;
                     per_cnt <= '0;
                     state   <= SETTLE;
                  end else begin
                     busy_r <= 1'b0;
                     state  <= IDLE;
                  end
               end
               default: begin
                  busy_r <= 1'b0;
                  state  <= IDLE;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_pwm_sar_adc_ctrl.sv
// Scoreboard bench for pwm_sar_adc_ctrl (DATA_W=4, SETTLE_PERIODS=2, 33 cycles per bit)
// with a closed-loop comparator model that low-pass filters ad_pwm over one period.
module tb_pwm_sar_adc_ctrl;

   localparam int DW  = 4;
   localparam int SP  = 2;
   localparam int NB  = SP * (1 << DW) + 1;
   localparam int LAT = DW * NB;

   typedef struct {
      logic [DW-1:0] data;
      int            cycle;
   } exp_t;

   logic clock;
   logic reset;
   logic comp_in;
   logic ad_pwm;

   pwm_sar_adc_ctrl_if #(.DATA_W(DW)) bus ();

   pwm_sar_adc_ctrl #(
      .DATA_W         (DW),
      .SETTLE_PERIODS (SP)
   ) dut (
      .clock   (clock),
      .reset   (reset),
      .comp_in (comp_in),
      .ad_pwm  (ad_pwm),
      .bus     (bus)
   );

   exp_t sb[$];
   int   vectors    = 0;
   int   miscompares = 0;
   int   cyc        = 0;
   int   compMode   = 0;
   int   tripCode   = 0;
   logic [15:0] win = '0;

   initial clock = 1'b0;
   always #5 clock = ~clock;

   always @(posedge clock) cyc <= cyc + 1;

   // Comparator: Vdac is the mean of the last 16 ad_pwm samples; mode 0/1 hold the output
   always @(negedge clock) begin
      win <= {win[14:0], ad_pwm};
      case (compMode)
         0:       comp_in <= 1'b0;
         1:       comp_in <= 1'b1;
         default: comp_in <= ($countones({win[14:0], ad_pwm}) <= tripCode);
      endcase
   end

   task automatic checkOutput(input string name, input int actual, input int expected);
      vectors++;
      if (actual !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
      end
   endtask

   // Monitor: every valid pulse must match the oldest scoreboard entry
   always @(negedge clock) begin
      if (reset === 1'b1 && bus.valid === 1'b1) begin
         if (sb.size() == 0) begin
            checkOutput("unexpected_valid", 1, 0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            checkOutput("data_out", int'(bus.data_out), int'(e.data));
            checkOutput("valid_cycle", cyc, e.cycle);
         end
      end
   end

   task automatic waitCyc(input int c);
      while (cyc < c) @(negedge clock);
   endtask

   task automatic applyStimulus(input logic s, input logic a);
      @(negedge clock);
      bus.start = s;
      bus.abort = a;
   endtask

   task automatic pulseStart(output int acc);
      applyStimulus(1'b1, 1'b0);
      @(posedge clock);
      #1;
      acc = cyc;
      bus.start = 1'b0;
   endtask

   task automatic pushExp(input logic [DW-1:0] d, input int c);
      exp_t e;
      e.data  = d;
      e.cycle = c;
      sb.push_back(e);
   endtask

   task automatic waitDrain(input int budget);
      int n = 0;
      while (sb.size() != 0 && n < budget) begin
         @(negedge clock);
         n++;
      end
      @(negedge clock);
      if (sb.size() != 0) begin
         checkOutput("drain_timeout", sb.size(), 0);
         sb.delete();
      end
   endtask

   initial begin
      int acc;
      int hi;
      reset       = 1'b0;
      comp_in     = 1'b0;
      bus.start   = 1'b0;
      bus.cont_en = 1'b0;
      bus.abort   = 1'b0;
      #22;
      checkOutput("rst_busy", int'(bus.busy), 0);
      checkOutput("rst_valid", int'(bus.valid), 0);
      checkOutput("rst_data", int'(bus.data_out), 0);
      checkOutput("rst_pwm", int'(ad_pwm), 0);
      @(negedge clock);
      reset = 1'b1;
      repeat (3) @(negedge clock);

      // 1: comparator always high -> 4'hF after LAT cycles
      compMode = 1;
      pulseStart(acc);
      pushExp(4'hF, acc + LAT);
      checkOutput("busy_after_start", int'(bus.busy), 1);
      waitDrain(LAT + 20);

      // 2: trip at code 5 -> trials 8,4,6,5
      compMode = 2; tripCode = 5;
      pulseStart(acc);
      pushExp(4'h5, acc + LAT);
      waitDrain(LAT + 20);

      // 3: comparator low -> result 0, duty 8,4,2,1 per bit
      compMode = 0;
      pulseStart(acc);
      pushExp(4'h0, acc + LAT);
      for (int k = 0; k < DW; k++) begin
         hi = 0;
         for (int j = 17; j <= 32; j++) begin
            waitCyc(acc + NB * k + j);
            if (ad_pwm === 1'b1) hi++;
         end
         checkOutput($sformatf("duty_bit%0d", k), hi, 8 >> k);
      end
      waitDrain(LAT + 20);
      checkOutput("idle_pwm", int'(ad_pwm), 0);

      // 4: continuous mode, trip at 10, three results then stop
      compMode = 2; tripCode = 10;
      bus.cont_en = 1'b1;
      pulseStart(acc);
      for (int r = 0; r < 3; r++) pushExp(4'hA, acc + LAT + r * (LAT + 1));
      waitCyc(acc + 2 * (LAT + 1) + 40);
      bus.cont_en = 1'b0;
      waitDrain(2 * LAT + 50);
      waitCyc(acc + 3 * LAT + 2 + 2);
      checkOutput("cont_stop_busy", int'(bus.busy), 0);

      // 5: abort mid-conversion, then start+abort in IDLE
      compMode = 1;
      pulseStart(acc);
      waitCyc(acc + 50);
      bus.abort = 1'b1;
      waitCyc(acc + 51);
      checkOutput("abort_busy", int'(bus.busy), 0);
      checkOutput("abort_pwm", int'(ad_pwm), 0);
      checkOutput("abort_data", int'(bus.data_out), 10);
      bus.abort = 1'b0;
      repeat (LAT + 10) @(negedge clock);
      applyStimulus(1'b1, 1'b1);
      applyStimulus(1'b0, 1'b0);
      checkOutput("start_abort_idle", int'(bus.busy), 0);
      repeat (LAT + 10) @(negedge clock);

      // 6a: start while busy is ignored
      pulseStart(acc);
      pushExp(4'hF, acc + LAT);
      waitCyc(acc + 10);
      pulseStart(hi);
      waitCyc(acc + 100);
      pulseStart(hi);
      waitDrain(LAT + 20);
      repeat (LAT + 20) @(negedge clock);
      checkOutput("busy_start_ignored", int'(bus.busy), 0);

      // 6b: asynchronous reset mid-SETTLE, between clock edges
      compMode = 2; tripCode = 10;
      pulseStart(acc);
      waitCyc(acc + 40);
      #2;
      reset = 1'b0;
      #1;
      checkOutput("async_rst_busy", int'(bus.busy), 0);
      checkOutput("async_rst_pwm", int'(ad_pwm), 0);
      checkOutput("async_rst_data", int'(bus.data_out), 0);
      checkOutput("async_rst_valid", int'(bus.valid), 0);
      repeat (2) @(negedge clock);
      reset = 1'b1;
      repeat (LAT + 10) @(negedge clock);
      checkOutput("post_rst_idle", int'(bus.busy), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
